// File: rtl/ppu_pkg.sv
// Shared PPU types: VRAM owner tags and palette address range.
// Imported by the VRAM arbiter and its owner-tag pipe.
package ppu_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_BG   = 2'd1,
    OWN_SPR  = 2'd2,
    OWN_RI   = 2'd3
  } own_e;

  localparam logic [5:0] PAL_HI = 6'h3F;

endpackage

// File: rtl/ppu_vram_tag_pipe.sv
// Owner-tag delay line, RD_LAT stages, async clear.
// Ports: clk_in, nrst_in, tag_in (issued owner), tag_out (returning owner).
module ppu_vram_tag_pipe
  import ppu_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic clk_in,
  input  logic nrst_in,
  input  own_e tag_in,
  output own_e tag_out
);

  own_e pipe_q [RD_LAT];

  always_ff @(posedge clk_in or negedge nrst_in) begin
    if (!nrst_in) begin
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_q[i] <= OWN_NONE;
      end
    end else begin
      pipe_q[0] <= tag_in;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign tag_out = pipe_q[RD_LAT-1];

endmodule

// File: rtl/ppu_vram_arb.sv
// PPU VRAM arbiter: bg / spr / CPU-side requesters onto one bus.
// Ports: per-requester req/addr in, gnt/vld out; VRAM a/d/wr out, d in.
module ppu_vram_arb
  import ppu_pkg::*;
#(
  parameter int AW         = 14,
  parameter int DW         = 8,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 8
) (
  input  logic          clk_in,
  input  logic          nrst_in,
  input  logic          rendering_in,
  input  logic          bg_req_in,
  input  logic [AW-1:0] bg_a_in,
  output logic          bg_gnt_out,
  output logic          bg_vld_out,
  input  logic          spr_req_in,
  input  logic [AW-1:0] spr_a_in,
  output logic          spr_gnt_out,
  output logic          spr_vld_out,
  input  logic          ri_req_in,
  input  logic          ri_wr_in,
  input  logic [AW-1:0] ri_a_in,
  input  logic [DW-1:0] ri_d_in,
  output logic          ri_gnt_out,
  output logic          ri_vld_out,
  output logic [DW-1:0] rd_d_out,
  output logic [AW-1:0] vram_a_out,
  output logic [DW-1:0] vram_d_out,
  output logic          vram_wr_out,
  input  logic [DW-1:0] vram_d_in
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

  logic          bg_el;
  logic          spr_el;
  logic          ri_el;
  logic          ri_pal;
  logic          ri_do_wr;
  own_e          win;
  own_e          tag_in;
  own_e          tag_out;
  logic [SW-1:0] starve_q;
  logic [SW-1:0] starve_d;

  // A requester whose grant is showing this cycle sits out one pick.
  assign bg_el  = bg_req_in  & ~bg_gnt_out;
  assign spr_el = spr_req_in & ~spr_gnt_out;
  assign ri_el  = ri_req_in  & ~ri_gnt_out;

  assign ri_pal   = (ri_a_in[AW-1:AW-6] == PAL_HI);
  assign ri_do_wr = ri_wr_in & ~ri_pal;

  always_comb begin
    win = OWN_NONE;
    if (rendering_in) begin
      if (ri_el && starve_q == SMAX) begin
        win = OWN_RI;
      end else if (bg_el) begin
        win = OWN_BG;
      end else if (spr_el) begin
        win = OWN_SPR;
      end else if (ri_el) begin
        win = OWN_RI;
      end
    end else begin
      if (ri_el) begin
        win = OWN_RI;
      end else if (spr_el) begin
        win = OWN_SPR;
      end else if (bg_el) begin
        win = OWN_BG;
      end
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (!ri_req_in || win == OWN_RI) begin
      starve_d = '0;
    end else if (starve_q != SMAX) begin
      starve_d = starve_q + 1'b1;
    end
  end

  // Writes (palette ones included) return nothing.
  always_comb begin
    tag_in = win;
    if (win == OWN_RI && ri_wr_in) begin
      tag_in = OWN_NONE;
    end
  end

  always_ff @(posedge clk_in or negedge nrst_in) begin
    if (!nrst_in) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

  always_ff @(posedge clk_in or negedge nrst_in) begin
    if (!nrst_in) begin
      bg_gnt_out  <= 1'b0;
      spr_gnt_out <= 1'b0;
      ri_gnt_out  <= 1'b0;
      vram_a_out  <= '0;
      vram_d_out  <= '0;
      vram_wr_out <= 1'b0;
    end else begin
      bg_gnt_out  <= (win == OWN_BG);
      spr_gnt_out <= (win == OWN_SPR);
      ri_gnt_out  <= (win == OWN_RI);
      vram_wr_out <= 1'b0;
      unique case (win)
        OWN_BG: begin
          vram_a_out <= bg_a_in;
        end
        OWN_SPR: begin
          vram_a_out <= spr_a_in;
        end
        OWN_RI: begin
          vram_a_out <= ri_a_in;
          if (ri_do_wr) begin
            vram_d_out  <= ri_d_in;
            vram_wr_out <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  ppu_vram_tag_pipe #(
    .RD_LAT (RD_LAT)
  ) u_tag_pipe (
    .clk_in  (clk_in),
    .nrst_in (nrst_in),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  always_ff @(posedge clk_in or negedge nrst_in) begin
    if (!nrst_in) begin
      bg_vld_out  <= 1'b0;
      spr_vld_out <= 1'b0;
      ri_vld_out  <= 1'b0;
      rd_d_out    <= '0;
    end else begin
      bg_vld_out  <= (tag_out == OWN_BG);
      spr_vld_out <= (tag_out == OWN_SPR);
      ri_vld_out  <= (tag_out == OWN_RI);
      if (tag_out != OWN_NONE) begin
        rd_d_out <= vram_d_in;
      end
    end
  end

endmodule

// File: tb/tb_ppu_vram_arb.sv
// Directed bench for ppu_vram_arb at RD_LAT=1 (u1) and RD_LAT=3 (u3).
// Both instances share stimulus; each has its own VRAM data model.
module tb_ppu_vram_arb;

  logic        clk = 1'b0;
  logic        nrst;
  logic        rendering;
  logic        bg_req;
  logic [13:0] bg_a;
  logic        spr_req;
  logic [13:0] spr_a;
  logic        ri_req;
  logic        ri_wr;
  logic [13:0] ri_a;
  logic [7:0]  ri_d;

  logic        bg_gnt1, bg_vld1, spr_gnt1, spr_vld1, ri_gnt1, ri_vld1;
  logic [7:0]  rd1, vd1, vdin1;
  logic [13:0] va1;
  logic        vwr1;

  logic        bg_gnt3, bg_vld3, spr_gnt3, spr_vld3, ri_gnt3, ri_vld3;
  logic [7:0]  rd3, vd3, vdin3;
  logic [13:0] va3;
  logic        vwr3;
  logic [13:0] a3_d1, a3_d2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] mem(input logic [13:0] a);
    if (a == 14'h23C0) return 8'h5A;
    return a[7:0] ^ {a[13:8], 2'b01};
  endfunction

  assign vdin1 = mem(va1);

  always @(posedge clk) begin
    a3_d1 <= va3;
    a3_d2 <= a3_d1;
  end
  assign vdin3 = mem(a3_d2);

  ppu_vram_arb #(.RD_LAT(1)) u1 (
    .clk_in(clk), .nrst_in(nrst), .rendering_in(rendering),
    .bg_req_in(bg_req), .bg_a_in(bg_a),
    .bg_gnt_out(bg_gnt1), .bg_vld_out(bg_vld1),
    .spr_req_in(spr_req), .spr_a_in(spr_a),
    .spr_gnt_out(spr_gnt1), .spr_vld_out(spr_vld1),
    .ri_req_in(ri_req), .ri_wr_in(ri_wr),
    .ri_a_in(ri_a), .ri_d_in(ri_d),
    .ri_gnt_out(ri_gnt1), .ri_vld_out(ri_vld1),
    .rd_d_out(rd1), .vram_a_out(va1), .vram_d_out(vd1),
    .vram_wr_out(vwr1), .vram_d_in(vdin1)
  );

  ppu_vram_arb #(.RD_LAT(3)) u3 (
    .clk_in(clk), .nrst_in(nrst), .rendering_in(rendering),
    .bg_req_in(bg_req), .bg_a_in(bg_a),
    .bg_gnt_out(bg_gnt3), .bg_vld_out(bg_vld3),
    .spr_req_in(spr_req), .spr_a_in(spr_a),
    .spr_gnt_out(spr_gnt3), .spr_vld_out(spr_vld3),
    .ri_req_in(ri_req), .ri_wr_in(ri_wr),
    .ri_a_in(ri_a), .ri_d_in(ri_d),
    .ri_gnt_out(ri_gnt3), .ri_vld_out(ri_vld3),
    .rd_d_out(rd3), .vram_a_out(va3), .vram_d_out(vd3),
    .vram_wr_out(vwr3), .vram_d_in(vdin3)
  );

  task automatic chk(input string tag, input logic [39:0] obs,
                     input logic [39:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [39:0] outs1();
    return {bg_gnt1, bg_vld1, spr_gnt1, spr_vld1, ri_gnt1, ri_vld1,
            rd1, va1, vd1, vwr1};
  endfunction

  function automatic logic [39:0] outs3();
    return {bg_gnt3, bg_vld3, spr_gnt3, spr_vld3, ri_gnt3, ri_vld3,
            rd3, va3, vd3, vwr3};
  endfunction

  logic [2:0] exp_gnt [9];

  initial begin
    exp_gnt = '{3'b100, 3'b010, 3'b100, 3'b010, 3'b100,
                3'b010, 3'b100, 3'b010, 3'b001};

    // Reset held with every requester asking.
    nrst      = 1'b0;
    rendering = 1'b1;
    bg_req    = 1'b1;
    bg_a      = 14'h2000;
    spr_req   = 1'b1;
    spr_a     = 14'h1010;
    ri_req    = 1'b1;
    ri_wr     = 1'b0;
    ri_a      = 14'h2100;
    ri_d      = 8'h00;
    repeat (3) tick();
    chk("rst_outs_u1", outs1(), 40'h0);
    chk("rst_outs_u3", outs3(), 40'h0);
    nrst = 1'b1;

    // Rendering: bg/spr alternate, ri forced through on 9th grant.
    for (int i = 0; i < 9; i++) begin
      tick();
      chk($sformatf("starve_gnt%0d", i),
          {37'h0, bg_gnt1, spr_gnt1, ri_gnt1}, {37'h0, exp_gnt[i]});
      if (i == 0) chk("e1_addr", {26'h0, va1}, {26'h0, 14'h2000});
      if (i == 1) begin
        chk("e2_addr", {26'h0, va1}, {26'h0, 14'h1010});
        chk("e2_bg_vld", {39'h0, bg_vld1}, 40'h1);
        chk("e2_rd", {32'h0, rd1}, {32'h0, 8'h81});
      end
      if (i == 8) chk("e9_addr", {26'h0, va1}, {26'h0, 14'h2100});
    end
    ri_req  = 1'b0;
    bg_req  = 1'b0;
    spr_req = 1'b0;
    rendering = 1'b0;
    repeat (4) tick();

    // CPU read from nametable attribute area.
    ri_req = 1'b1;
    ri_wr  = 1'b0;
    ri_a   = 14'h23C0;
    tick();
    chk("rd_gnt", {39'h0, ri_gnt1}, 40'h1);
    chk("rd_addr", {26'h0, va1}, {26'h0, 14'h23C0});
    ri_req = 1'b0;
    tick();
    chk("rd_vld", {37'h0, bg_vld1, spr_vld1, ri_vld1}, 40'h1);
    chk("rd_data", {32'h0, rd1}, {32'h0, 8'h5A});

    // CPU write to nametable.
    tick();
    ri_req = 1'b1;
    ri_wr  = 1'b1;
    ri_a   = 14'h2001;
    ri_d   = 8'hA5;
    tick();
    chk("wr_gnt_wr", {38'h0, ri_gnt1, vwr1}, 40'h3);
    chk("wr_data", {32'h0, vd1}, {32'h0, 8'hA5});
    chk("wr_addr", {26'h0, va1}, {26'h0, 14'h2001});
    ri_req = 1'b0;
    tick();
    chk("wr_after", {37'h0, vwr1, ri_vld1, ri_gnt1}, 40'h0);

    // CPU write to palette: granted, no VRAM strobe.
    ri_req = 1'b1;
    ri_a   = 14'h3F01;
    ri_d   = 8'h77;
    tick();
    chk("pal_gnt_wr", {38'h0, ri_gnt1, vwr1}, 40'h2);
    chk("pal_addr", {26'h0, va1}, {26'h0, 14'h3F01});
    chk("pal_d_hold", {32'h0, vd1}, {32'h0, 8'hA5});
    ri_req = 1'b0;
    ri_wr  = 1'b0;
    tick();
    chk("pal_after", {38'h0, vwr1, ri_vld1}, 40'h0);
    tick();

    // RD_LAT=3: back-to-back bg then spr reads.
    rendering = 1'b1;
    bg_req  = 1'b1;
    spr_req = 1'b1;
    tick();
    chk("l3_bg_gnt", {38'h0, bg_gnt3, spr_gnt3}, 40'h2);
    bg_req = 1'b0;
    tick();
    chk("l3_spr_gnt", {38'h0, bg_gnt3, spr_gnt3}, 40'h1);
    spr_req = 1'b0;
    tick();
    chk("l3_n3_vld", {37'h0, bg_vld3, spr_vld3, ri_vld3}, 40'h0);
    tick();
    chk("l3_bg_vld", {37'h0, bg_vld3, spr_vld3, ri_vld3}, 40'h4);
    chk("l3_bg_data", {32'h0, rd3}, {32'h0, 8'h81});
    tick();
    chk("l3_spr_vld", {37'h0, bg_vld3, spr_vld3, ri_vld3}, 40'h2);
    chk("l3_spr_data", {32'h0, rd3}, {32'h0, 8'h51});
    repeat (2) tick();

    // Reset while two reads are in flight.
    bg_req  = 1'b1;
    spr_req = 1'b1;
    tick();
    bg_req = 1'b0;
    tick();
    spr_req = 1'b0;
    #2;
    nrst = 1'b0;
    #1;
    chk("async_rst_u3", outs3(), 40'h0);
    chk("async_rst_u1", outs1(), 40'h0);
    tick();
    tick();
    nrst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("post_rst_vld%0d", i),
          {37'h0, bg_vld3, spr_vld3, ri_vld3}, 40'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
